// File: rtl/regs_wb_ctrl.sv
// regs_wb_ctrl -- writeback controller for the 32x32 register file.
//
// Arbitrates the ex (ALU) and lsu (load) writeback requesters onto the single
// register-file write port with round-robin priority, and keeps a per-register
// pending-write scoreboard that stalls id on RAW hazards and throttles issue
// when a register already has three writes outstanding.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   ex_valid_i/waddr/wdata      ex writeback request; ex_ready_o = accepted
//   lsu_valid_i/waddr/wdata     lsu writeback request; lsu_ready_o = accepted
//   reg_waddr_o/wdata_o/wen_o   registered write port towards regs
//   issue_valid_i/issue_rd_i    id issuing an instruction that writes rd
//   issue_ready_o               issue may proceed (no pending-count overflow)
//   rs1_raddr_i/rs2_raddr_i     id source registers
//   stall_o                     RAW hazard, id must hold
//
// Round-robin pointer (only consulted when both requesters are valid):
//   state   | meaning
//   PTR_EX  | ex wins the next conflict
//   PTR_LSU | lsu wins the next conflict
module regs_wb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              ex_ready_o,
  input  logic              lsu_valid_i,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_ready_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_wen_o,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  output logic              issue_ready_o,
  input  logic [ADDR_W-1:0] rs1_raddr_i,
  input  logic [ADDR_W-1:0] rs2_raddr_i,
  output logic              stall_o
);

  typedef enum logic {PTR_EX = 1'b0, PTR_LSU = 1'b1} ptr_t;

  ptr_t ptr, ptr_nxt;
  logic ex_gnt, lsu_gnt;

  logic [1:0]      cnt [NREG];
  logic [NREG-1:0] inc_vec, dec_vec;
  logic            issue_fire;

  // ---------------- arbitration ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= PTR_EX;
    else      ptr <= ptr_nxt;
  end

  always_comb begin
    ptr_nxt = ptr;
    ex_gnt  = 1'b0;
    lsu_gnt = 1'b0;
    if (ex_valid_i && lsu_valid_i) begin
      if (ptr == PTR_EX) begin
        ex_gnt  = 1'b1;
        ptr_nxt = PTR_LSU;
      end else begin
        lsu_gnt = 1'b1;
        ptr_nxt = PTR_EX;
      end
    end else begin
      ex_gnt  = ex_valid_i;
      lsu_gnt = lsu_valid_i;
    end
  end

  assign ex_ready_o  = ex_gnt;
  assign lsu_ready_o = lsu_gnt;

  // ---------------- output stage ----------------
  // Address/data follow every accepted request (including x0); wen is
  // suppressed for x0 so regs never sees it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_wen_o   <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else begin
      reg_wen_o <= 1'b0;
      if (ex_gnt) begin
        reg_waddr_o <= ex_waddr_i;
        reg_wdata_o <= ex_wdata_i;
        reg_wen_o   <= (ex_waddr_i != '0);
      end else if (lsu_gnt) begin
        reg_waddr_o <= lsu_waddr_i;
        reg_wdata_o <= lsu_wdata_i;
        reg_wen_o   <= (lsu_waddr_i != '0);
      end
    end
  end

  // ---------------- scoreboard ----------------
  // A write retiring this cycle frees a slot, so a full counter can still
  // accept a new issue to the same register.
  assign issue_ready_o = !((cnt[issue_rd_i] == 2'd3) && !dec_vec[issue_rd_i]);
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire) inc_vec[issue_rd_i] = 1'b1;
    if (reg_wen_o)  dec_vec[reg_waddr_o] = 1'b1;
  end

  // cnt[0] is only ever reset, so x0 never looks pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + 2'd1;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != 2'd0))
          cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

  // A writeback nobody issued would corrupt the hazard tracking.
  always @(posedge clk) begin
    if (rst && reg_wen_o)
      assert (cnt[reg_waddr_o] != 2'd0)
        else $error("regs_wb_ctrl: writeback to x%0d with no pending write", reg_waddr_o);
  end

  // ---------------- hazard stall ----------------
  // No stall when regs is writing the last pending value this cycle: regs
  // forwards that data to id.
  always_comb begin
    stall_o = 1'b0;
    if ((rs1_raddr_i != '0) && (cnt[rs1_raddr_i] != 2'd0) &&
        !(dec_vec[rs1_raddr_i] && (cnt[rs1_raddr_i] == 2'd1)))
      stall_o = 1'b1;
    if ((rs2_raddr_i != '0) && (cnt[rs2_raddr_i] != 2'd0) &&
        !(dec_vec[rs2_raddr_i] && (cnt[rs2_raddr_i] == 2'd1)))
      stall_o = 1'b1;
  end

endmodule

// File: tb/tb_regs_wb_ctrl.sv
module tb_regs_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  ex_waddr = '0, lsu_waddr = '0, issue_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] ex_wdata = '0, lsu_wdata = '0;
  logic        ex_ready, lsu_ready, reg_wen, issue_ready, stall;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  int checks = 0;
  int errors = 0;

  regs_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready),
    .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata), .reg_wen_o(reg_wen),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .rs1_raddr_i(rs1), .rs2_raddr_i(rs2), .stall_o(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pend[r]: number of issued-but-not-yet-written values for register r.
  int          pend [32];
  bit          pref_lsu;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  function automatic bit m_ex_gnt();
    return ex_valid && (!lsu_valid || !pref_lsu);
  endfunction
  function automatic bit m_lsu_gnt();
    return lsu_valid && !m_ex_gnt();
  endfunction
  function automatic bit m_writing(input logic [4:0] r);
    return m_wen && (m_waddr == r);
  endfunction
  function automatic bit m_issue_ready();
    return (pend[issue_rd] < 3) || m_writing(issue_rd);
  endfunction
  function automatic bit m_haz(input logic [4:0] r);
    return (r != 0) && (pend[r] != 0) && !(m_writing(r) && pend[r] == 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit eg, lg, ir;
    if (!rst) begin
      foreach (pend[i]) pend[i] = 0;
      pref_lsu = 1'b0;
      m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      eg = m_ex_gnt();
      lg = m_lsu_gnt();
      ir = m_issue_ready();
      if (issue_valid && ir && issue_rd != 0) pend[issue_rd]++;
      if (m_wen && pend[m_waddr] > 0) pend[m_waddr]--;
      if (ex_valid && lsu_valid) pref_lsu = !pref_lsu;
      if (eg) begin
        m_waddr = ex_waddr; m_wdata = ex_wdata; m_wen = (ex_waddr != 0);
      end else if (lg) begin
        m_waddr = lsu_waddr; m_wdata = lsu_wdata; m_wen = (lsu_waddr != 0);
      end else begin
        m_wen = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("ex_ready",    ex_ready,    m_ex_gnt());
      chk("lsu_ready",   lsu_ready,   m_lsu_gnt());
      chk("reg_wen",     reg_wen,     m_wen);
      chk("reg_waddr",   reg_waddr,   m_waddr);
      chk("reg_wdata",   reg_wdata,   m_wdata);
      chk("issue_ready", issue_ready, m_issue_ready());
      chk("stall",       stall,       m_haz(rs1) || m_haz(rs2));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    rs1 = 5'd5;
    repeat (2) nxt();
    chk("rst_wen", reg_wen, 0);
    chk("rst_waddr", reg_waddr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_ex_ready", ex_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_stall", stall, 0);
    mid(); rst = 1'b1;

    // 1: single ex writeback
    nxt(); issue_valid = 1; issue_rd = 5;
    nxt(); issue_valid = 0; ex_valid = 1; ex_waddr = 5; ex_wdata = 32'hDEADBEEF;
    mid(); chk("t1_ex_ready", ex_ready, 1);
    nxt(); ex_valid = 0;
    mid(); chk("t1_wen", reg_wen, 1); chk("t1_waddr", reg_waddr, 5);
    chk("t1_wdata", reg_wdata, 32'hDEADBEEF); chk("t1_bypass_stall", stall, 0);

    // 2: round-robin conflict
    nxt(); issue_valid = 1; issue_rd = 3;
    nxt();
    nxt(); issue_rd = 4;
    nxt(); issue_valid = 0;
    ex_valid = 1; ex_waddr = 3; ex_wdata = 32'h11;
    lsu_valid = 1; lsu_waddr = 4; lsu_wdata = 32'h22;
    mid(); chk("t2_c0_ex_ready", ex_ready, 1); chk("t2_c0_lsu_ready", lsu_ready, 0);
    nxt(); ex_wdata = 32'h33;
    mid(); chk("t2_c1_lsu_ready", lsu_ready, 1); chk("t2_c1_ex_ready", ex_ready, 0);
    chk("t2_c1_waddr", reg_waddr, 3); chk("t2_c1_wdata", reg_wdata, 32'h11);
    nxt(); lsu_valid = 0;
    mid(); chk("t2_c2_ex_ready", ex_ready, 1);
    chk("t2_c2_waddr", reg_waddr, 4); chk("t2_c2_wdata", reg_wdata, 32'h22);
    nxt(); ex_valid = 0;
    mid(); chk("t2_c3_waddr", reg_waddr, 3); chk("t2_c3_wdata", reg_wdata, 32'h33);

    // 3: RAW stall and bypass release
    nxt(); issue_valid = 1; issue_rd = 7; rs1 = 7;
    nxt(); issue_valid = 0;
    mid(); chk("t3_stall_rs1", stall, 1);
    nxt(); rs1 = 0; rs2 = 7;
    mid(); chk("t3_stall_rs2", stall, 1);
    nxt(); ex_valid = 1; ex_waddr = 7; ex_wdata = 32'h77;
    mid(); chk("t3_stall_accept", stall, 1);
    nxt(); ex_valid = 0;
    mid(); chk("t3_wen", reg_wen, 1); chk("t3_waddr", reg_waddr, 7);
    chk("t3_stall_bypass", stall, 0);
    nxt();
    mid(); chk("t3_stall_after", stall, 0);
    rs2 = 0;

    // 4: pending-count saturation
    nxt(); issue_valid = 1; issue_rd = 9;
    nxt();
    nxt();
    nxt();
    mid(); chk("t4_full", issue_ready, 0);
    nxt(); ex_valid = 1; ex_waddr = 9; ex_wdata = 32'h99;
    mid(); chk("t4_full_accept", issue_ready, 0);
    nxt(); ex_valid = 0;
    mid(); chk("t4_retire_ready", issue_ready, 1); chk("t4_retire_wen", reg_wen, 1);
    nxt();
    mid(); chk("t4_still_full", issue_ready, 0);
    nxt(); issue_valid = 0; ex_valid = 1;
    nxt();
    nxt();
    nxt(); ex_valid = 0; rs1 = 9;
    nxt();
    mid(); chk("t4_drained", stall, 0);

    // 5: x0 handling
    nxt(); lsu_valid = 1; lsu_waddr = 0; lsu_wdata = 32'h55;
    issue_valid = 1; issue_rd = 0; rs1 = 0;
    mid(); chk("t5_lsu_ready", lsu_ready, 1); chk("t5_issue_ready", issue_ready, 1);
    chk("t5_stall", stall, 0);
    nxt(); lsu_valid = 0; issue_valid = 0;
    mid(); chk("t5_wen", reg_wen, 0); chk("t5_stall_after", stall, 0);

    // 6: reset with a write in the output stage
    nxt(); issue_valid = 1; issue_rd = 12; rs1 = 12;
    nxt(); issue_valid = 0; ex_valid = 1; ex_waddr = 12; ex_wdata = 32'hC;
    nxt(); ex_valid = 0;
    mid(); chk("t6_wen_before", reg_wen, 1);
    rst = 1'b0; #1;
    chk("t6_wen_async", reg_wen, 0); chk("t6_waddr_async", reg_waddr, 0);
    chk("t6_stall_rst", stall, 0); chk("t6_issue_ready_rst", issue_ready, 1);
    nxt();
    mid(); rst = 1'b1;
    nxt();
    mid(); chk("t6_stall_after", stall, 0); chk("t6_wen_after", reg_wen, 0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_wb_ctrl.md
Name: regs_wb_ctrl

Overview:
- Writeback controller for the 32x32 register file.
- Arbitrates two writeback requesters onto the single register-file write port: ex (ALU results) and lsu (load data). Uses valid/ready handshakes and round-robin priority.
- Keeps a per-register pending-write scoreboard that stalls id on RAW hazards and throttles issue on WAW overflow.
- Sits between ex/lsu and regs, and beside id.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NREG, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  ex has a writeback pending.
- ex_waddr_i  in  ADDR_W  ex destination register.
- ex_wdata_i  in  DATA_W  ex result.
- ex_ready_o  out  1  ex writeback accepted this cycle.
- lsu_valid_i  in  1  lsu has a writeback pending.
- lsu_waddr_i  in  ADDR_W  lsu destination register.
- lsu_wdata_i  in  DATA_W  lsu load data.
- lsu_ready_o  out  1  lsu writeback accepted this cycle.
- reg_waddr_o  out  ADDR_W  to regs write address, registered.
- reg_wdata_o  out  DATA_W  to regs write data, registered.
- reg_wen_o  out  1  to regs write enable, registered.
- issue_valid_i  in  1  id issues an instruction that writes issue_rd_i.
- issue_rd_i  in  ADDR_W  destination register of the issuing instruction.
- issue_ready_o  out  1  issue may proceed (no WAW counter overflow).
- rs1_raddr_i  in  ADDR_W  id source register 1.
- rs2_raddr_i  in  ADDR_W  id source register 2.
- stall_o  out  1  RAW hazard; id must hold.

Behaviour:

Reset:
- rst low, asynchronous: reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
- All pending counters are set to 0 and the round-robin pointer is set to ex.
- Combinational outputs then evaluate to ex_ready_o=lsu_ready_o=0, issue_ready_o=1, stall_o=0.
- Reset mid-operation discards any in-flight write: nothing reaches regs after rst falls.

Arbitration (combinational grant):
- Only ex valid: ex granted.
- Only lsu valid: lsu granted.
- Both valid: the requester the pointer selects is granted, and the pointer then flips to the other requester.
- A single-requester grant leaves the pointer unchanged.
- ready_o is high only for the granted requester. The output stage accepts every cycle, so a valid request never waits more than 1 cycle.
- A transfer occurs when valid && ready. A requester holds addr/data stable while valid && !ready.

Output stage:
- The accepted request is registered and drives reg_* the next cycle (1-cycle latency).
- reg_wen_o = 1 only if a transfer occurred and waddr != 0.
- A write to x0 completes its handshake but produces reg_wen_o=0.
- With no transfer, reg_wen_o=0 and reg_waddr_o/reg_wdata_o hold their previous values.

Scoreboard (per register r, 2-bit counter cnt[r], x0 is never tracked):
- Increment: issue_valid_i && issue_ready_o && issue_rd_i==r && r!=0.
- Decrement: reg_wen_o && reg_waddr_o==r.
- Increment and decrement of the same r in the same cycle: cnt unchanged.
- issue_ready_o = 0 when cnt[issue_rd_i]==3 and no decrement of that register occurs this cycle; otherwise 1. The counter never wraps.
- A decrement at cnt==0 is a protocol error: the counter saturates at 0 and a simulation-only assertion flags it.

Hazard stall (combinational):
- stall_o is asserted if, for rs1 or for rs2: raddr != 0, cnt[raddr] != 0, and NOT (reg_wen_o && reg_waddr_o==raddr && cnt[raddr]==1).
- The exception covers the case where regs is writing that register this cycle and this is its last pending write; regs bypasses the data to id, so no stall is needed.

Arithmetic:
- Addresses are unsigned and compared at full width.
- Data passes through unmodified.

Test Plan:
1. Reset release, ex_valid=1, waddr=5, wdata=0xDEADBEEF -> ex_ready=1 same cycle; next cycle reg_wen=1, reg_waddr=5, reg_wdata=0xDEADBEEF.
2. ex (x3, 0x11) and lsu (x4, 0x22) both valid for 2 cycles, pointer=ex -> cycle0 grants ex, cycle1 grants lsu; reg_* shows x3/0x11 then x4/0x22; the stalled requester holds its data.
3. Issue rd=7, then rs1=7 with no writeback -> stall_o=1 each cycle; ex writes x7 -> in the cycle reg_wen_o=1 with waddr=7, stall_o=0 and cnt[7]=0 afterwards.
4. Issue rd=9 three times with no writeback -> issue_ready_o=0 on the fourth attempt; with a concurrent reg_wen_o to x9 -> issue_ready_o=1 and cnt[9] stays 3.
5. Writeback to x0 via lsu; issue rd=0; rs1=0 -> handshake completes, reg_wen_o=0, cnt unchanged, stall_o=0.
6. Assert rst low while an accepted request sits in the output stage -> reg_wen_o=0 immediately (asynchronously); all counters 0; stall_o=0 after release.
